// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the writeback stage (source selects, load types, counter CSRs).
package wb_pkg;

   typedef enum logic [2:0] {
      WB_ALU  = 3'b000,
      WB_PC4  = 3'b001,
      WB_LOAD = 3'b110,
      WB_CSR  = 3'b111
   } wb_sel_e;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LD  = 3'b011,
      LBU = 3'b100,
      LHU = 3'b101,
      LWU = 3'b110
   } ld_type_e;

   localparam logic [11:0] CSR_CYCLE    = 12'hC00;
   localparam logic [11:0] CSR_INSTRET  = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH = 12'hC82;

endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: shifts the raw memory word to the load byte offset, extends it by load type
// and flags offsets/types that the load cannot legally use.
module wb_load_align
   import wb_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int OFS_W = $clog2(XLEN/8)
) (
   input  logic [XLEN-1:0]  i_load_raw,
   input  logic [OFS_W-1:0] i_addr_lo,
   input  logic [2:0]       i_funct3,
   output logic [XLEN-1:0]  o_data,
   output logic             o_misalign
);

   logic [XLEN-1:0] w_sh;
   logic            w_quad;

   assign w_sh   = i_load_raw >> {i_addr_lo, 3'b000};
   assign w_quad = i_addr_lo[1:0] == 2'b00;

   always_comb begin
      o_data     = '0;
      o_misalign = 1'b0;
      case (i_funct3)
         LB:  o_data = XLEN'($signed(w_sh[7:0]));
         LBU: o_data = XLEN'(w_sh[7:0]);
         LH:  begin
            o_data     = XLEN'($signed(w_sh[15:0]));
            o_misalign = i_addr_lo[0];
         end
         LHU: begin
            o_data     = XLEN'(w_sh[15:0]);
            o_misalign = i_addr_lo[0];
         end
         LW:  begin
            o_data     = XLEN'($signed(w_sh[31:0]));
            o_misalign = !w_quad;
         end
         LWU: begin
            o_data     = XLEN'(w_sh[31:0]);
            o_misalign = (XLEN != 64) || !w_quad;
         end
         LD:  begin
            o_data     = w_sh;
            o_misalign = (XLEN != 64) || (i_addr_lo != '0);
         end
         default: o_misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/wb_unit.sv
// wb_unit: MEM/WB pipeline register, cycle/instret counters, CSR counter reads and
// register-file write data/enable generation.
module wb_unit
   import wb_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64,
   parameter int OFS_W = $clog2(XLEN/8)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             m_valid,
   input  logic [2:0]       m_wb_sel,
   input  logic [4:0]       m_rd,
   input  logic             m_rd_we,
   input  logic [XLEN-1:0]  m_alu,
   input  logic [XLEN-1:0]  m_pc4,
   input  logic [XLEN-1:0]  m_load_raw,
   input  logic [OFS_W-1:0] m_addr_lo,
   input  logic [2:0]       m_funct3,
   input  logic [11:0]      m_csr_addr,
   output logic             wb_valid,
   output logic             wb_we,
   output logic [4:0]       wb_rd,
   output logic [XLEN-1:0]  wb_data,
   output logic             wb_ld_misalign,
   output logic             wb_csr_illegal
);

   logic             r_valid;
   logic [2:0]       r_sel;
   logic [4:0]       r_rd;
   logic             r_rd_we;
   logic [XLEN-1:0]  r_alu;
   logic [XLEN-1:0]  r_pc4;
   logic [XLEN-1:0]  r_load_raw;
   logic [OFS_W-1:0] r_addr_lo;
   logic [2:0]       r_funct3;
   logic [11:0]      r_csr_addr;
   logic [CNT_W-1:0] r_cycle;
   logic [CNT_W-1:0] r_instret;

   logic [XLEN-1:0]  w_ld_data;
   logic             w_ld_mis;
   logic [63:0]      w_cyc64;
   logic [63:0]      w_ins64;
   logic [XLEN-1:0]  w_csr_data;
   logic             w_csr_ok;
   logic             w_sel_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid    <= 1'b0;
         r_sel      <= '0;
         r_rd       <= '0;
         r_rd_we    <= 1'b0;
         r_alu      <= '0;
         r_pc4      <= '0;
         r_load_raw <= '0;
         r_addr_lo  <= '0;
         r_funct3   <= '0;
         r_csr_addr <= '0;
         r_cycle    <= '0;
         r_instret  <= '0;
      end else begin
         r_cycle <= r_cycle + CNT_W'(1);
         if (r_valid && !stall)
            r_instret <= r_instret + CNT_W'(1);
         if (flush) begin
            r_valid <= 1'b0;
            r_rd_we <= 1'b0;
         end else if (!stall) begin
            r_valid    <= m_valid;
            r_sel      <= m_wb_sel;
            r_rd       <= m_rd;
            r_rd_we    <= m_rd_we;
            r_alu      <= m_alu;
            r_pc4      <= m_pc4;
            r_load_raw <= m_load_raw;
            r_addr_lo  <= m_addr_lo;
            r_funct3   <= m_funct3;
            r_csr_addr <= m_csr_addr;
         end
      end
   end

   wb_load_align #(.XLEN(XLEN), .OFS_W(OFS_W)) u_align (
      .i_load_raw (r_load_raw),
      .i_addr_lo  (r_addr_lo),
      .i_funct3   (r_funct3),
      .o_data     (w_ld_data),
      .o_misalign (w_ld_mis)
   );

   // Counters are widened to 64 bits so bits at and above CNT_W read as zero.
   assign w_cyc64 = 64'(r_cycle);
   assign w_ins64 = 64'(r_instret);

   always_comb begin
      w_csr_data = '0;
      w_csr_ok   = 1'b1;
      case (r_csr_addr)
         CSR_CYCLE:    w_csr_data = w_cyc64[XLEN-1:0];
         CSR_INSTRET:  w_csr_data = w_ins64[XLEN-1:0];
         CSR_CYCLEH:   begin
            w_csr_data = (XLEN == 32) ? XLEN'(w_cyc64[63:32]) : '0;
            w_csr_ok   = XLEN == 32;
         end
         CSR_INSTRETH: begin
            w_csr_data = (XLEN == 32) ? XLEN'(w_ins64[63:32]) : '0;
            w_csr_ok   = XLEN == 32;
         end
         default:      w_csr_ok = 1'b0;
      endcase
   end

   assign w_sel_ok = r_sel == WB_ALU || r_sel == WB_PC4 || r_sel == WB_LOAD || r_sel == WB_CSR;

   assign wb_valid       = r_valid;
   assign wb_rd          = r_rd;
   assign wb_ld_misalign = r_valid && r_sel == WB_LOAD && w_ld_mis;
   assign wb_csr_illegal = r_valid && r_sel == WB_CSR && !w_csr_ok;
   assign wb_we          = r_valid && r_rd_we && r_rd != 5'd0 && !wb_ld_misalign
                           && !wb_csr_illegal && w_sel_ok;

   always_comb
      wb_data = r_sel == WB_ALU  ? r_alu :
                r_sel == WB_PC4  ? r_pc4 :
                r_sel == WB_LOAD ? (w_ld_mis ? '0 : w_ld_data) :
                r_sel == WB_CSR  ? w_csr_data : '0;

endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: directed checks of wb_unit (XLEN=32) with a 64-bit and a 32-bit counter instance.
module tb_wb_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        m_valid = 1'b0;
   logic [2:0]  m_wb_sel = '0;
   logic [4:0]  m_rd = '0;
   logic        m_rd_we = 1'b0;
   logic [31:0] m_alu = '0;
   logic [31:0] m_pc4 = '0;
   logic [31:0] m_load_raw = '0;
   logic [1:0]  m_addr_lo = '0;
   logic [2:0]  m_funct3 = '0;
   logic [11:0] m_csr_addr = '0;

   logic        wb_valid, wb_we, wb_ld_misalign, wb_csr_illegal;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb2_valid, wb2_we, wb2_ld_misalign, wb2_csr_illegal;
   logic [4:0]  wb2_rd;
   logic [31:0] wb2_data;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_unit #(.XLEN(32), .CNT_W(64)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .m_valid(m_valid), .m_wb_sel(m_wb_sel), .m_rd(m_rd), .m_rd_we(m_rd_we),
      .m_alu(m_alu), .m_pc4(m_pc4), .m_load_raw(m_load_raw), .m_addr_lo(m_addr_lo),
      .m_funct3(m_funct3), .m_csr_addr(m_csr_addr),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_ld_misalign(wb_ld_misalign), .wb_csr_illegal(wb_csr_illegal)
   );

   wb_unit #(.XLEN(32), .CNT_W(32)) dut2 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .m_valid(m_valid), .m_wb_sel(m_wb_sel), .m_rd(m_rd), .m_rd_we(m_rd_we),
      .m_alu(m_alu), .m_pc4(m_pc4), .m_load_raw(m_load_raw), .m_addr_lo(m_addr_lo),
      .m_funct3(m_funct3), .m_csr_addr(m_csr_addr),
      .wb_valid(wb2_valid), .wb_we(wb2_we), .wb_rd(wb2_rd), .wb_data(wb2_data),
      .wb_ld_misalign(wb2_ld_misalign), .wb_csr_illegal(wb2_csr_illegal)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      m_valid = 1'b0; m_rd_we = 1'b0; m_wb_sel = '0; m_rd = '0;
      m_alu = '0; m_pc4 = '0; m_load_raw = '0; m_addr_lo = '0; m_funct3 = '0; m_csr_addr = '0;
   endtask

   // Valid writing instruction; unselected sources carry distinct junk.
   task automatic instr(input logic [2:0] sel, input logic [4:0] rd, input logic [31:0] a,
                        input logic [2:0] f3, input logic [1:0] lo, input logic [11:0] csr);
      m_valid = 1'b1; m_rd_we = 1'b1; m_wb_sel = sel; m_rd = rd;
      m_alu = (sel == 3'b000) ? a : 32'hA1A1A1A1;
      m_pc4 = (sel == 3'b001) ? a : 32'hB2B2B2B2;
      m_load_raw = (sel == 3'b110) ? a : 32'hC3C3C3C3;
      m_funct3 = f3; m_addr_lo = lo; m_csr_addr = csr;
   endtask

   initial begin
      instr(3'b000, 5'd1, 32'h1234, 3'b000, 2'd0, 12'h000);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(wb_valid), 64'd0);
      chk("rst_we", 64'(wb_we), 64'd0);
      chk("rst_data", 64'(wb_data), 64'd0);
      chk("rst_rd", 64'(wb_rd), 64'd0);
      chk("rst_flags", 64'({wb_ld_misalign, wb_csr_illegal}), 64'd0);

      @(negedge clk);
      rst = 1'b1;
      idle();
      repeat (8) step();
      instr(3'b111, 5'd3, 32'h0, 3'b000, 2'd0, 12'hC02);
      step();
      chk("instret_initial", 64'(wb_data), 64'd0);
      chk("csr_we", 64'(wb_we), 64'd1);
      instr(3'b111, 5'd3, 32'h0, 3'b000, 2'd0, 12'hC00);
      step();
      chk("cycle_10", 64'(wb_data), 64'd10);
      chk("cycle_10_cnt32", 64'(wb2_data), 64'd10);

      instr(3'b110, 5'd4, 32'h80FF7F01, 3'b000, 2'd1, 12'h000);
      step();
      chk("lb_ofs1", 64'(wb_data), 64'h0000007F);
      instr(3'b110, 5'd4, 32'h80FF7F01, 3'b000, 2'd3, 12'h000);
      step();
      chk("lb_ofs3", 64'(wb_data), 64'hFFFFFF80);
      instr(3'b110, 5'd4, 32'h80FF7F01, 3'b101, 2'd2, 12'h000);
      step();
      chk("lhu_ofs2", 64'(wb_data), 64'h000080FF);
      chk("lhu_we", 64'(wb_we), 64'd1);
      instr(3'b110, 5'd4, 32'h80FF7F01, 3'b010, 2'd2, 12'h000);
      step();
      chk("lw_misalign", 64'(wb_ld_misalign), 64'd1);
      chk("lw_mis_we", 64'(wb_we), 64'd0);
      chk("lw_mis_data", 64'(wb_data), 64'd0);

      instr(3'b001, 5'd5, 32'h00001004, 3'b000, 2'd0, 12'h000);
      step();
      chk("pc4_data", 64'(wb_data), 64'h00001004);
      chk("pc4_we", 64'(wb_we), 64'd1);
      chk("pc4_rd", 64'(wb_rd), 64'd5);
      instr(3'b001, 5'd0, 32'h00001004, 3'b000, 2'd0, 12'h000);
      step();
      chk("rd0_we", 64'(wb_we), 64'd0);
      instr(3'b010, 5'd5, 32'h00001004, 3'b000, 2'd0, 12'h000);
      step();
      chk("badsel_data", 64'(wb_data), 64'd0);
      chk("badsel_we", 64'(wb_we), 64'd0);

      instr(3'b111, 5'd3, 32'h0, 3'b000, 2'd0, 12'hC02);
      step();
      chk("instret_9", 64'(wb_data), 64'd9);

      stall = 1'b1;
      instr(3'b000, 5'd6, 32'hDEAD, 3'b000, 2'd0, 12'h000);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_hold_instret", 64'(wb_data), 64'd9);
      end
      chk("stall_hold_rd", 64'(wb_rd), 64'd3);
      stall = 1'b0;
      step();
      chk("stall_release_data", 64'(wb_data), 64'hDEAD);
      instr(3'b111, 5'd3, 32'h0, 3'b000, 2'd0, 12'hC02);
      step();
      chk("instret_after_stall", 64'(wb_data), 64'd11);

      stall = 1'b1;
      flush = 1'b1;
      instr(3'b000, 5'd6, 32'hBEEF, 3'b000, 2'd0, 12'h000);
      step();
      chk("flush_valid", 64'(wb_valid), 64'd0);
      chk("flush_we", 64'(wb_we), 64'd0);
      stall = 1'b0;
      flush = 1'b0;
      instr(3'b111, 5'd3, 32'h0, 3'b000, 2'd0, 12'hC02);
      step();
      chk("instret_after_flush", 64'(wb_data), 64'd11);

      instr(3'b111, 5'd3, 32'h0, 3'b000, 2'd0, 12'h300);
      step();
      chk("csr_illegal", 64'(wb_csr_illegal), 64'd1);
      chk("csr_illegal_we", 64'(wb_we), 64'd0);
      chk("csr_illegal_data", 64'(wb_data), 64'd0);

      instr(3'b111, 5'd3, 32'h0, 3'b000, 2'd0, 12'hC00);
      step();
      force dut2.r_cycle = 32'hFFFFFFFF;
      #1;
      chk("wrap_preload", 64'(wb2_data), 64'hFFFFFFFF);
      release dut2.r_cycle;
      stall = 1'b1;
      step();
      chk("wrap_zero", 64'(wb2_data), 64'd0);
      chk("cycle_28", 64'(wb_data), 64'd28);
      stall = 1'b0;
      instr(3'b111, 5'd3, 32'h0, 3'b000, 2'd0, 12'hC80);
      step();
      chk("cycleh_cnt32", 64'(wb2_data), 64'd0);
      chk("cycleh_cnt32_legal", 64'(wb2_csr_illegal), 64'd0);
      chk("cycleh_cnt64", 64'(wb_data), 64'd0);

      instr(3'b000, 5'd7, 32'h55, 3'b000, 2'd0, 12'h000);
      step();
      chk("pre_reset_data", 64'(wb_data), 64'h55);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_valid", 64'(wb_valid), 64'd0);
      chk("async_rst_we", 64'(wb_we), 64'd0);
      chk("async_rst_data", 64'(wb_data), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      instr(3'b111, 5'd3, 32'h0, 3'b000, 2'd0, 12'hC00);
      step();
      chk("cycle_after_rst", 64'(wb_data), 64'd1);
      instr(3'b111, 5'd3, 32'h0, 3'b000, 2'd0, 12'hC02);
      step();
      chk("instret_after_rst", 64'(wb_data), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/wb_unit.md
# wb_unit

Parametrised writeback stage for the in-order RISC-V core. It holds the MEM/WB pipeline register with stall and flush control, and aligns and extends load data by width and byte offset. It keeps the 64-bit cycle and instret counters internally and selects the register-file write data among ALU, link (PC+4), load and counter-CSR sources. It drives the register-file write port and the forwarding path.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64
- CNT_W, 64, counter width; legal values 32 to 64
- OFS_W, $clog2(XLEN/8), byte-offset width (derived; do not override)

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- stall  in  1  hold WB register contents
- flush  in  1  load a bubble into WB register
- m_valid  in  1  MEM-stage instruction valid
- m_wb_sel  in  3  source select: ALU / PC4 / LOAD / CSR
- m_rd  in  5  destination register
- m_rd_we  in  1  instruction writes rd
- m_alu  in  XLEN  ALU result
- m_pc4  in  XLEN  link address
- m_load_raw  in  XLEN  raw aligned memory word
- m_addr_lo  in  OFS_W  load byte offset
- m_funct3  in  3  load type
- m_csr_addr  in  12  CSR address for counter reads
- wb_valid  out  1  WB instruction valid (retiring)
- wb_we  out  1  register-file write enable
- wb_rd  out  5  register-file write address
- wb_data  out  XLEN  register-file write data
- wb_ld_misalign  out  1  misaligned-load flag
- wb_csr_illegal  out  1  unsupported counter CSR flag

## Operation
- WB register fields: valid, wb_sel, rd, rd_we, alu, pc4, load_raw, addr_lo, funct3, csr_addr.
- Register update priority on each posedge: flush > stall > load.
  - flush: valid and rd_we are cleared; other fields are don't-care.
  - stall: all fields hold.
  - otherwise: all fields load from the m_* inputs.
- Select encoding:
  - 3'b000 ALU
  - 3'b001 PC4
  - 3'b110 LOAD
  - 3'b111 CSR
  - any other code: wb_data = 0, wb_we = 0.
- Load alignment, by funct3:
  - LB 000 and LBU 100: byte at offset, any offset.
  - LH 001 and LHU 101: offset must be even.
  - LW 010: offset must be a multiple of 4.
  - LWU 110 and LD 011: legal only when XLEN=64; LD requires offset 0.
  - Signed loads sign-extend to XLEN; unsigned loads zero-extend.
  - An illegal offset or illegal funct3 sets wb_ld_misalign = valid, forces wb_we = 0 and wb_data = 0.
- Counters:
  - cycle increments by 1 every clock after reset.
  - instret increments by 1 on each clock edge where wb_valid=1 and stall=0.
  - Both wrap from 2^CNT_W−1 to 0.
- CSR reads return the pre-increment counter values of the current cycle:
  - 0xC00 returns cycle[XLEN−1:0].
  - 0xC02 returns instret[XLEN−1:0].
  - 0xC80 and 0xC82 return the upper 32 bits of cycle and instret; legal only when XLEN=32.
  - Any other address gives data 0, wb_we = 0, and wb_csr_illegal = valid.
  - When CNT_W < 64, bits at and above CNT_W read as 0.
- Output gating: wb_we = valid & rd_we & (rd≠0) & no misalign & no csr_illegal & legal select.

## Timing
- Latency: one cycle from the m_* inputs to the WB register.
  - wb_data, wb_we, wb_rd and the flags are combinational from the WB register and the counters.
- Reset (async assert, sync-free release):
  - WB register valid = 0; all fields = 0.
  - cycle = 0, instret = 0.
  - All outputs = 0.
- First clock edge after reset release: cycle becomes 1.
- Reset asserted mid-operation: the in-flight WB instruction is dropped; no write and no instret increment.
- stall and flush asserted together: flush wins; the bubble does not retire.
- Stall held N cycles on a valid instruction: instret increments exactly once, on the edge where stall deasserts.
- CSR read during stall: data tracks the live cycle counter each stalled cycle.
  - Only the value present on the retiring edge is architectural.

## Structure
- Package wb_pkg holds:
  - typedef enum logic [2:0] wb_sel_e (WB_ALU, WB_PC4, WB_LOAD, WB_CSR)
  - typedef enum logic [2:0] ld_type_e (LB, LH, LW, LD, LBU, LHU, LWU)
  - localparam CSR addresses: CSR_CYCLE, CSR_INSTRET, CSR_CYCLEH, CSR_INSTRETH
- One sub-module: wb_load_align, purely combinational.
  - Inputs: load_raw, addr_lo, funct3.
  - Outputs: load data, misalign flag.
  - Parameter: XLEN.
- WB register, counters, CSR decode and output mux stay in wb_unit.

## Test plan
- Reset, then 10 idle cycles:
  - read 0xC00 via a valid CSR instruction → 10.
  - read 0xC02 → 0.
  - all outputs 0 while rst = 0.
- XLEN=32 loads, raw = 0x80FF7F01:
  - LB offset 1 → 0x0000007F.
  - LB offset 3 → 0xFFFFFF80.
  - LHU offset 2 → 0x000080FF.
  - LW offset 2 → misalign = 1, wb_we = 0.
- Sources:
  - sel=001, pc4 = 0x00001004, rd = 5 → wb_data = 0x00001004, wb_we = 1.
  - same with rd = 0 → wb_we = 0.
  - sel=010 → wb_data = 0, wb_we = 0.
- Stall and flush:
  - valid instruction, stall held 3 cycles → instret +1 only after release.
  - stall and flush in the same cycle → wb_valid = 0 next cycle, instret unchanged.
- Counter wrap: CNT_W=32, XLEN=32:
  - preload cycle to 0xFFFFFFFF by running cycles or via a force in the bench; next edge → 0.
  - 0xC80 → 0.
- CSR and async-reset edge cases:
  - csr_addr 0x300 with valid = 1 → wb_csr_illegal = 1, wb_we = 0.
  - rst asserted between edges → outputs 0 immediately, without waiting for clk.
